// File: rtl/init_reset_sequencer.sv
// Power-up reset sequencer: synchronizes the supply/PLL/init status inputs,
// waits for them to stay good for a qualification window, then releases
// three reset domains in order, one every RELEASE_GAP clocks. A watchdog
// covers the bring-up window; a qualifier lost mid-release is latched as a
// fault until software clears it.
// STABLE_CYCLES must be at least 2.
module init_reset_sequencer #(
  parameter int         SYNC_STAGES    = 2,
  parameter int         STABLE_CYCLES  = 16,
  parameter int         RELEASE_GAP    = 8,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter logic [6:0] BANK_MASK      = 7'b1111111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fabric_por_n,
  input  logic       device_init_done,
  input  logic [6:0] bank_vddi_status,
  input  logic       pll_lock,
  input  logic       clear_fault,
  output logic [2:0] rst_out,
  output logic       init_ok,
  output logic       init_fault,
  output logic [1:0] fault_code,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    WAIT_POR  = 3'd0,
    WAIT_INIT = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  localparam int STAB_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int REL_W  = $clog2(2 * RELEASE_GAP + 1);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [REL_W-1:0]  REL_MID   = REL_W'(RELEASE_GAP);
  localparam logic [REL_W-1:0]  REL_END   = REL_W'(2 * RELEASE_GAP);
  localparam logic [16:0]       TMO_LIMIT = 17'(TIMEOUT_CYCLES);

  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_QLOST   = 2'b10;

  // ---------------------------------------------------------------------------
  // Input synchronizers: one SYNC_STAGES-deep chain per status bit.
  // ---------------------------------------------------------------------------
  logic [9:0]                   async_in;
  logic [SYNC_STAGES-1:0][9:0]  sync_q;
  logic                         por_s, init_s, pll_s, qual;
  logic [6:0]                   bank_s;

  assign async_in = {pll_lock, bank_vddi_status, device_init_done, fabric_por_n};

  // Shift every status bit one stage deeper each clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge value of its neighbour, as real hardware does.
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign por_s  = sync_q[SYNC_STAGES-1][0];
  assign init_s = sync_q[SYNC_STAGES-1][1];
  assign bank_s = sync_q[SYNC_STAGES-1][8:2];
  assign pll_s  = sync_q[SYNC_STAGES-1][9];
  assign qual   = por_s & init_s & pll_s & (&(bank_s | ~BANK_MASK));

  // ---------------------------------------------------------------------------
  // Sequencer FSM and counters.
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [REL_W-1:0]  rel_q, rel_d;
  logic [15:0]       tmo_q, tmo_d, tmo_inc;
  logic [1:0]        code_q, code_d;
  logic [2:0]        rst_d;
  logic              timeout_hit;

  // The watchdog saturates so a stuck bring-up never wraps back to zero.
  assign tmo_inc     = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
  assign timeout_hit = ({1'b0, tmo_q} + 17'd1) >= TMO_LIMIT;

  // Next-state, next-counter and next-output decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    stab_d  = stab_q;
    rel_d   = rel_q;
    tmo_d   = tmo_q;
    code_d  = code_q;

    case (state_q)
      WAIT_POR: begin
        if (por_s) begin
          state_d = WAIT_INIT;
          tmo_d   = '0;
        end
      end
      WAIT_INIT: begin
        tmo_d = tmo_inc;
        if (!por_s) begin
          state_d = WAIT_POR;
        end else if (timeout_hit) begin
          state_d = FAULT;
          code_d  = CODE_TIMEOUT;
        end else if (qual) begin
          state_d = STABLE;
          stab_d  = '0;
        end
      end
      STABLE: begin
        tmo_d = tmo_inc;
        if (!por_s) begin
          state_d = WAIT_POR;
        end else if (timeout_hit) begin
          state_d = FAULT;
          code_d  = CODE_TIMEOUT;
        end else if (!qual) begin
          state_d = WAIT_INIT;
        end else begin
          stab_d = stab_q + 1'b1;
          if (stab_d == STAB_LAST) begin
            state_d = RELEASE;
            rel_d   = '0;
          end
        end
      end
      RELEASE: begin
        tmo_d = tmo_inc;
        if (!por_s) begin
          state_d = WAIT_POR;
        end else if (timeout_hit) begin
          state_d = FAULT;
          code_d  = CODE_TIMEOUT;
        end else if (!qual) begin
          state_d = FAULT;
          code_d  = CODE_QLOST;
        end else begin
          rel_d = rel_q + 1'b1;
          if (rel_d == REL_END) state_d = RUN;
        end
      end
      RUN: begin
        if (!por_s) begin
          state_d = WAIT_POR;
        end else if (!qual) begin
          // A fresh bring-up attempt gets a fresh watchdog window.
          state_d = WAIT_INIT;
          tmo_d   = '0;
        end
      end
      FAULT: begin
        if (clear_fault) state_d = WAIT_POR;
      end
      default: state_d = WAIT_POR;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    case (state_d)
      RELEASE: rst_d = {1'b1, (rel_d < REL_MID), 1'b0};
      RUN:     rst_d = 3'b000;
      default: rst_d = 3'b111;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_POR;
      stab_q     <= '0;
      rel_q      <= '0;
      tmo_q      <= '0;
      code_q     <= '0;
      rst_out    <= 3'b111;
      init_ok    <= 1'b0;
      init_fault <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_q     <= stab_d;
      rel_q      <= rel_d;
      tmo_q      <= tmo_d;
      code_q     <= code_d;
      rst_out    <= rst_d;
      init_ok    <= (state_d == RUN);
      init_fault <= (state_d == FAULT);
    end
  end

  assign fault_code = code_q;
  assign state      = state_q;

endmodule
